// File: rtl/barrel_shifter.sv
// ---------------------------------------------------------------------------
// barrel_shifter
//
// Registered barrel shifter / rotator with a one-cycle latency.
//
// The datapath is a chain of log2(WIDTH) mux stages. Stage k moves the data
// by 2**k positions when bit k of the shift amount is set, and passes it
// through unchanged otherwise. A single output register follows the chain,
// so no input has a combinational path to out or out_valid.
//
// Parameters
//   WIDTH      data width in bits (power of two, 2..64)
//   SEL_W      select width, must equal log2(WIDTH)+1
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears out and out_valid)
//   in         data to shift or rotate
//   sel        sel[SEL_W-1] = direction (0 left, 1 right),
//              sel[SEL_W-2:0] = shift amount 0..WIDTH-1
//   mode       00 rotate, 01 logical shift, 10 arithmetic shift,
//              11 reserved (data passes through unchanged)
//   in_valid   qualifies in, sel and mode in the current cycle
//   out        registered result, holds when no input is accepted
//   out_valid  one-cycle pulse per accepted input
// ---------------------------------------------------------------------------
module barrel_shifter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int STAGES = $clog2(WIDTH);

    localparam logic [1:0] MODE_ROTATE   = 2'b00;
    localparam logic [1:0] MODE_ARITH    = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    logic              dir_right;
    logic [STAGES-1:0] amount;
    logic              is_rotate;
    logic              fill_bit;
    logic [WIDTH-1:0]  stage_data [0:STAGES];
    logic [WIDTH-1:0]  result;

    assign dir_right = sel[SEL_W-1];
    assign amount    = sel[SEL_W-2:0];
    assign is_rotate = (mode == MODE_ROTATE);

    // Vacated positions get zero, except on an arithmetic right shift where
    // they get the sign bit. Using in[WIDTH-1] for every stage is correct
    // because an arithmetic right shift never changes the MSB, so each
    // intermediate stage still carries the original sign there.
    assign fill_bit = (mode == MODE_ARITH) && dir_right && in[WIDTH-1];

    assign stage_data[0] = in;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int S = 1 << k;

            logic [WIDTH-1:0] stage_in;
            logic [WIDTH-1:0] shifted_left;
            logic [WIDTH-1:0] shifted_right;

            assign stage_in = stage_data[k];

            // Left: rotate wraps the top S bits to the bottom; shifts
            // (logical and arithmetic alike) fill the bottom with zeros.
            assign shifted_left = is_rotate
                ? {stage_in[WIDTH-1-S:0], stage_in[WIDTH-1:WIDTH-S]}
                : {stage_in[WIDTH-1-S:0], {S{1'b0}}};

            // Right: rotate wraps the bottom S bits to the top; shifts
            // fill the top with the selected fill bit.
            assign shifted_right = is_rotate
                ? {stage_in[S-1:0], stage_in[WIDTH-1:S]}
                : {{S{fill_bit}}, stage_in[WIDTH-1:S]};

            assign stage_data[k+1] = amount[k]
                ? (dir_right ? shifted_right : shifted_left)
                : stage_in;
        end
    endgenerate

    // The reserved mode bypasses the mux chain so the data is returned as-is
    // whatever the amount field holds.
    assign result = (mode == MODE_RESERVED) ? in : stage_data[STAGES];

    // Output register. out only loads on an accepted input so it holds the
    // last result through idle cycles; out_valid follows in_valid so it
    // pulses exactly once per accepted input. Reset clears both, which also
    // drops any result that was about to be presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= result;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_barrel_shifter
//
// Directed bench for barrel_shifter at WIDTH=4. Inputs are driven on the
// falling edge and outputs are sampled 1 time unit after the rising edge.
// Ends with a randomised run against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_barrel_shifter;

    localparam int WIDTH = 4;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic [SEL_W-1:0] sel;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] dout;
    logic             out_valid;

    int errors;
    int checks;

    barrel_shifter #(
        .WIDTH(WIDTH),
        .SEL_W(SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din),
        .sel      (sel),
        .mode     (mode),
        .in_valid (in_valid),
        .out      (dout),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: rotate via a doubled word, shifts via the
    // language shift operators.
    function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] d,
                                                   input logic [SEL_W-1:0] s,
                                                   input logic [1:0] m);
        logic [2*WIDTH-1:0] dbl;
        logic [SEL_W-2:0]   n;
        logic               right;
        logic [WIDTH-1:0]   r;
        n     = s[SEL_W-2:0];
        right = s[SEL_W-1];
        dbl   = {d, d};
        case (m)
            2'b00: begin
                if (right) begin
                    dbl = dbl >> n;
                    r   = dbl[WIDTH-1:0];
                end else begin
                    dbl = dbl << n;
                    r   = dbl[2*WIDTH-1:WIDTH];
                end
            end
            2'b01:   r = right ? (d >> n) : (d << n);
            2'b10:   r = right ? WIDTH'($signed(d) >>> n) : (d << n);
            default: r = d;
        endcase
        return r;
    endfunction

    // Drive one set of inputs on the falling edge, then advance to just
    // after the rising edge that samples them.
    task automatic apply_stimulus(input logic [WIDTH-1:0] d,
                                  input logic [SEL_W-1:0] s,
                                  input logic [1:0] m,
                                  input logic v);
        @(negedge clk);
        din      = d;
        sel      = s;
        mode     = m;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag,
                                input logic [WIDTH-1:0] exp_out,
                                input logic exp_valid);
        checks++;
        assert (dout === exp_out) else begin
            errors++;
            $error("[TB] FAIL %s out: observed=%h expected=%h", tag, dout, exp_out);
        end
        checks++;
        assert (out_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s out_valid: observed=%b expected=%b", tag, out_valid, exp_valid);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rin;
        logic [SEL_W-1:0] rsel;
        logic [1:0]       rmode;
        logic             rvalid;
        logic [WIDTH-1:0] exp_out;
        logic [WIDTH-1:0] rot_exp [0:7];

        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        din      = '0;
        sel      = '0;
        mode     = 2'b00;
        in_valid = 1'b0;

        // Reset asserted before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_output("reset_state", 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Rotate sweep of 4'hA over every select value.
        $display("[TB] rotate sweep");
        rot_exp = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(4'hA, SEL_W'(i), 2'b00, 1'b1);
            check_output($sformatf("rot_sel%0d", i), rot_exp[i], 1'b1);
        end

        // Logical shifts.
        $display("[TB] logical shifts");
        apply_stimulus(4'hA, 3'd1, 2'b01, 1'b1);
        check_output("lsl1_A", 4'h4, 1'b1);
        apply_stimulus(4'hA, 3'd3, 2'b01, 1'b1);
        check_output("lsl3_A", 4'h0, 1'b1);
        apply_stimulus(4'hA, 3'd5, 2'b01, 1'b1);
        check_output("lsr1_A", 4'h5, 1'b1);
        apply_stimulus(4'hA, 3'd7, 2'b01, 1'b1);
        check_output("lsr3_A", 4'h1, 1'b1);

        // Arithmetic shifts.
        $display("[TB] arithmetic shifts");
        apply_stimulus(4'hA, 3'd5, 2'b10, 1'b1);
        check_output("asr1_A", 4'hD, 1'b1);
        apply_stimulus(4'hA, 3'd7, 2'b10, 1'b1);
        check_output("asr3_A", 4'hF, 1'b1);
        apply_stimulus(4'hA, 3'd1, 2'b10, 1'b1);
        check_output("asl1_A", 4'h4, 1'b1);
        apply_stimulus(4'h5, 3'd6, 2'b10, 1'b1);
        check_output("asr2_5", 4'h1, 1'b1);

        // Zero amount and reserved mode pass the data through.
        apply_stimulus(4'hC, 3'd0, 2'b01, 1'b1);
        check_output("lsl0_C", 4'hC, 1'b1);
        apply_stimulus(4'h9, 3'd4, 2'b10, 1'b1);
        check_output("asr0_9", 4'h9, 1'b1);
        apply_stimulus(4'h7, 3'd3, 2'b11, 1'b1);
        check_output("reserved_7", 4'h7, 1'b1);
        apply_stimulus(4'hB, 3'd6, 2'b11, 1'b1);
        check_output("reserved_B", 4'hB, 1'b1);

        // Hold behaviour with in_valid low and changing inputs.
        $display("[TB] hold");
        apply_stimulus(4'h3, 3'd1, 2'b01, 1'b1);
        check_output("hold_accept", 4'h6, 1'b1);
        apply_stimulus(4'hF, 3'd2, 2'b00, 1'b0);
        check_output("hold_idle1", 4'h6, 1'b0);
        apply_stimulus(4'h8, 3'd5, 2'b10, 1'b0);
        check_output("hold_idle2", 4'h6, 1'b0);
        apply_stimulus(4'h1, 3'd7, 2'b01, 1'b0);
        check_output("hold_idle3", 4'h6, 1'b0);

        // Asynchronous reset in the middle of a cycle while a result is out.
        $display("[TB] async reset");
        apply_stimulus(4'hF, 3'd0, 2'b00, 1'b1);
        check_output("pre_reset", 4'hF, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset", 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check_output("reset_held", 4'h0, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_release_idle", 4'h0, 1'b0);
        apply_stimulus(4'h8, 3'd5, 2'b01, 1'b1);
        check_output("post_release_accept", 4'h4, 1'b1);

        // Randomised run against the reference model.
        $display("[TB] random run");
        exp_out = 4'h4;
        for (int i = 0; i < 1000; i++) begin
            rin    = WIDTH'($urandom);
            rsel   = SEL_W'($urandom);
            rmode  = 2'($urandom);
            rvalid = 1'($urandom);
            if (rvalid) begin
                exp_out = ref_model(rin, rsel, rmode);
            end
            apply_stimulus(rin, rsel, rmode, rvalid);
            check_output($sformatf("rand%0d_in%h_sel%0d_mode%0d", i, rin, rsel, rmode),
                         exp_out, rvalid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
